// File: rtl/i2c_bus_arbiter_pkg.sv
// Shared types and default timing for the I2C bus arbiter.
// Default timings assume clk at 50 MHz.
package i2c_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GUARD = 2'd2
  } arb_state_t;

  localparam int NUM_REQ_DEF        = 2;
  localparam int GUARD_CYCLES_DEF   = 250;        // 5 us, covers I2C tBUF
  localparam int TIMEOUT_CYCLES_DEF = 2_500_000;  // 50 ms

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// Request/grant and open-drain enable bundle between the I2C masters and the arbiter.
interface i2c_bus_arbiter_if #(
  parameter int NUM_REQ = 2
);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] scl_oe_in;
  logic [NUM_REQ-1:0] sda_oe_in;
  logic               scl_oe_out;
  logic               sda_oe_out;
  logic               bus_busy;
  logic               timeout_err;

  modport master (
    output req, scl_oe_in, sda_oe_in,
    input  grant, scl_oe_out, sda_oe_out, bus_busy, timeout_err
  );

  modport slave (
    input  req, scl_oe_in, sda_oe_in,
    output grant, scl_oe_out, sda_oe_out, bus_busy, timeout_err
  );

endinterface

// File: rtl/i2c_bus_arbiter_picker.sv
// Round-robin priority picker: first set request at or after ptr, wrapping.
// Purely combinational; returns the winner one-hot and as an index.
module rr_priority_picker
  import i2c_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   win_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    winner  = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = IDX_W'((int'(ptr) + off) % NUM_REQ);
      if (!found && req[cand]) begin
        winner[cand] = 1'b1;
        win_idx      = cand;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one open-drain I2C bus between NUM_REQ masters: round-robin grant held
// until release, guard gap between owners, watchdog revoke of overlong grants.
//
// state    | meaning
// ST_IDLE  | bus free, arbitrate among unmasked requests
// ST_GRANT | one master owns the bus, watchdog counting
// ST_GUARD | bus released, hold it idle for GUARD_CYCLES
module i2c_bus_arbiter
  import i2c_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = NUM_REQ_DEF,
  parameter int GUARD_CYCLES   = GUARD_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input logic              clk,
  input logic              reset_n,
  i2c_bus_arbiter_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = $clog2(max_int(GUARD_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] GUARD_TC   = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               timeout_q, timeout_d;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] winner;
  logic [IDX_W-1:0]   win_idx;

  assign eligible = bus.req & ~mask_q;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req     (eligible),
    .ptr     (ptr_q),
    .winner  (winner),
    .win_idx (win_idx)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      mask_q    <= '0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      owner_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    timeout_d = 1'b0;
    // A masked master is forgiven as soon as it lets go of its request.
    mask_d    = mask_q & bus.req;

    case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          grant_d = winner;
          owner_d = win_idx;
          ptr_d   = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
          cnt_d   = '0;
          state_d = ST_GRANT;
        end
      end

      ST_GRANT: begin
        // A release on the timeout edge wins: no error, no mask.
        if (!bus.req[owner_q]) begin
          grant_d = '0;
          cnt_d   = '0;
          state_d = ST_GUARD;
        end else if (cnt_q == TIMEOUT_TC) begin
          grant_d         = '0;
          cnt_d           = '0;
          timeout_d       = 1'b1;
          mask_d[owner_q] = 1'b1;
          state_d         = ST_GUARD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_GUARD: begin
        if (cnt_q >= GUARD_TC) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        grant_d = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.grant       = grant_q;
    bus.scl_oe_out  = |(bus.scl_oe_in & grant_q);
    bus.sda_oe_out  = |(bus.sda_oe_in & grant_q);
    bus.bus_busy    = (state_q != ST_IDLE);
    bus.timeout_err = timeout_q;
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Scoreboard bench for i2c_bus_arbiter: each driven cycle queues the outputs
// expected after the next clock edge; the checker pops and compares them.
module tb_i2c_bus_arbiter;

  localparam int NUM_REQ = 2;
  localparam int GUARD   = 4;
  localparam int TIMEOUT = 20;

  typedef struct {
    string      tag;
    logic [1:0] grant;
    logic       scl;
    logic       sda;
    logic       busy;
    logic       tout;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  i2c_bus_arbiter_if #(.NUM_REQ(NUM_REQ)) bus();

  i2c_bus_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .GUARD_CYCLES   (GUARD),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_cycle(input string tag, input logic [1:0] g, input logic scl,
                              input logic sda, input logic busy, input logic tout);
    exp_t e;
    e.tag = tag; e.grant = g; e.scl = scl; e.sda = sda; e.busy = busy; e.tout = tout;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq({e.tag, ".grant"}, 8'(bus.grant), 8'(e.grant));
    check_eq({e.tag, ".scl"}, 8'(bus.scl_oe_out), 8'(e.scl));
    check_eq({e.tag, ".sda"}, 8'(bus.sda_oe_out), 8'(e.sda));
    check_eq({e.tag, ".busy"}, 8'(bus.bus_busy), 8'(e.busy));
    check_eq({e.tag, ".tout"}, 8'(bus.timeout_err), 8'(e.tout));
  endtask

  // Owner's request already dropped: release edge plus guard, then idle.
  task automatic release_guard(input string tag);
    for (int i = 0; i < GUARD; i++) expect_cycle({tag, ".guard"}, 2'b00, 0, 0, 1, 0);
    expect_cycle({tag, ".idle"}, 2'b00, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset_n = 1'b0;
    bus.req = 2'b11;
    bus.scl_oe_in = 2'b11;
    bus.sda_oe_in = 2'b11;
    repeat (3) expect_cycle("reset", 2'b00, 0, 0, 0, 0);

    // Single request, oe mirroring and isolation
    reset_n = 1'b1; bus.req = 2'b00; bus.scl_oe_in = 2'b00; bus.sda_oe_in = 2'b00;
    expect_cycle("idle", 2'b00, 0, 0, 0, 0);
    bus.req = 2'b01;
    expect_cycle("single_grant", 2'b01, 0, 0, 1, 0);
    bus.scl_oe_in = 2'b01;
    expect_cycle("scl_mirror1", 2'b01, 1, 0, 1, 0);
    bus.scl_oe_in = 2'b00;
    expect_cycle("scl_mirror0", 2'b01, 0, 0, 1, 0);
    bus.scl_oe_in = 2'b01; bus.sda_oe_in = 2'b10;
    expect_cycle("isolation", 2'b01, 1, 0, 1, 0);
    bus.sda_oe_in = 2'b11;
    expect_cycle("sda_mirror", 2'b01, 1, 1, 1, 0);
    bus.scl_oe_in = 2'b00; bus.sda_oe_in = 2'b00; bus.req = 2'b00;
    release_guard("single_rel");

    // Round robin
    reset_n = 1'b0;
    expect_cycle("rr_reset", 2'b00, 0, 0, 0, 0);
    reset_n = 1'b1; bus.req = 2'b11;
    expect_cycle("rr_first", 2'b01, 0, 0, 1, 0);
    expect_cycle("rr_hold", 2'b01, 0, 0, 1, 0);
    bus.req = 2'b10;
    release_guard("rr_rel0");
    expect_cycle("rr_second", 2'b10, 0, 0, 1, 0);
    bus.req = 2'b00;
    release_guard("rr_rel1");
    bus.req = 2'b11;
    expect_cycle("rr_third", 2'b01, 0, 0, 1, 0);
    bus.req = 2'b00;
    release_guard("rr_rel2");

    // Watchdog timeout, mask, pending request
    bus.req = 2'b01;
    expect_cycle("to_grant", 2'b01, 0, 0, 1, 0);
    for (int i = 1; i < TIMEOUT; i++) begin
      if (i == 5) bus.req = 2'b11;
      expect_cycle("to_hold", 2'b01, 0, 0, 1, 0);
    end
    expect_cycle("to_revoke", 2'b00, 0, 0, 1, 1);
    for (int i = 1; i < GUARD; i++) expect_cycle("to_guard", 2'b00, 0, 0, 1, 0);
    expect_cycle("to_idle", 2'b00, 0, 0, 0, 0);
    expect_cycle("to_other", 2'b10, 0, 0, 1, 0);
    bus.req = 2'b01;
    release_guard("to_rel1");
    repeat (2) expect_cycle("to_masked", 2'b00, 0, 0, 0, 0);
    bus.req = 2'b00;
    expect_cycle("to_unmask", 2'b00, 0, 0, 0, 0);
    bus.req = 2'b01;
    expect_cycle("to_regrant", 2'b01, 0, 0, 1, 0);

    // Reset mid-grant
    bus.scl_oe_in = 2'b01; bus.sda_oe_in = 2'b01;
    expect_cycle("pre_rst", 2'b01, 1, 1, 1, 0);
    reset_n = 1'b0;
    expect_cycle("mid_rst", 2'b00, 0, 0, 0, 0);
    reset_n = 1'b1; bus.req = 2'b11; bus.scl_oe_in = 2'b00; bus.sda_oe_in = 2'b00;
    expect_cycle("post_rst", 2'b01, 0, 0, 1, 0);

    // Release on the same edge as the timeout: normal release
    for (int i = 1; i < TIMEOUT; i++) expect_cycle("tie_hold", 2'b01, 0, 0, 1, 0);
    bus.req = 2'b10;
    release_guard("tie_rel");
    expect_cycle("tie_next", 2'b10, 0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
